// File: rtl/control_unit.sv
// control_unit: microcoded fetch/decode/execute sequencer for the 16-bit SAP computer
// Ports: i_clk/i_rst (sync, active-high), i_step_en clock enable, i_instr IR contents,
//        i_flag_c/i_flag_z flags; o_bus_sel bus source, o_*_load register loads, o_ram_wr,
//        o_pc_inc/o_pc_load PC control, o_alu_op ALU operation, o_tstate T-state, o_halted.
module control_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_step_en,
  input  logic [15:0] i_instr,
  input  logic        i_flag_c,
  input  logic        i_flag_z,
  output logic [2:0]  o_bus_sel,
  output logic        o_mar_load,
  output logic        o_ram_wr,
  output logic        o_ir_load,
  output logic        o_pc_inc,
  output logic        o_pc_load,
  output logic        o_a_load,
  output logic        o_b_load,
  output logic        o_flags_load,
  output logic        o_out_load,
  output logic [3:0]  o_alu_op,
  output logic [2:0]  o_tstate,
  output logic        o_halted
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} tstate_t;
  localparam logic [2:0] BUS_PC = 3'd1, BUS_RAM = 3'd2, BUS_IR = 3'd3, BUS_A = 3'd4, BUS_ALU = 3'd5;
  tstate_t r_t;
  logic r_halted;
  logic [3:0] w_op;
  logic w_alu2, w_mem, w_last, w_run, w_unused;
  logic [3:0] w_alu_fn;
  assign w_op = i_instr[15:12];
  assign w_unused = ^i_instr[11:0];
  assign w_alu2 = w_op == 4'h2 || w_op == 4'h3 || w_op == 4'h9 || w_op == 4'hA || w_op == 4'hB;
  assign w_mem = w_op == 4'h1 || w_op == 4'h4;
  // T4 and the unreachable T5 always wrap; shorter instructions end at T2 or T3
  assign w_last = r_t >= T4 || (r_t == T3 && !w_alu2) || (r_t == T2 && !w_alu2 && !w_mem);
  assign w_run = !i_rst && i_step_en && !r_halted;
  assign w_alu_fn = w_op == 4'h3 ? 4'd1 :
                    w_op == 4'h9 ? 4'd4 :
                    w_op == 4'hA ? 4'd5 :
                    w_op == 4'hB ? 4'd6 :
                    w_op == 4'hC ? 4'd2 :
                    w_op == 4'hD ? 4'd3 : 4'd0;
  assign o_tstate = r_t;
  assign o_halted = r_halted;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_t <= T0;
      r_halted <= 1'b0;
    end else if (w_run) begin
      r_t <= w_last ? T0 : tstate_t'(r_t + 3'd1);
      r_halted <= r_t == T2 && w_op == 4'hF;
    end
  end
  always_comb begin
    o_bus_sel = 3'd0;
    o_mar_load = 1'b0;
    o_ram_wr = 1'b0;
    o_ir_load = 1'b0;
    o_pc_inc = 1'b0;
    o_pc_load = 1'b0;
    o_a_load = 1'b0;
    o_b_load = 1'b0;
    o_flags_load = 1'b0;
    o_out_load = 1'b0;
    o_alu_op = 4'd0;
    if (w_run) begin
      case (r_t)
        T0: begin
          o_bus_sel = BUS_PC;
          o_mar_load = 1'b1;
        end
        T1: begin
          o_bus_sel = BUS_RAM;
          o_ir_load = 1'b1;
          o_pc_inc = 1'b1;
        end
        T2: begin
          case (w_op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB: begin
              o_bus_sel = BUS_IR;
              o_mar_load = 1'b1;
            end
            4'h5: begin
              o_bus_sel = BUS_IR;
              o_a_load = 1'b1;
            end
            4'h6, 4'h7, 4'h8: begin
              o_bus_sel = BUS_IR;
              o_pc_load = w_op == 4'h6 || (w_op == 4'h7 && i_flag_c) || (w_op == 4'h8 && i_flag_z);
            end
            4'hC, 4'hD: begin
              o_bus_sel = BUS_ALU;
              o_alu_op = w_alu_fn;
              o_a_load = 1'b1;
              o_flags_load = 1'b1;
            end
            4'hE: begin
              o_bus_sel = BUS_A;
              o_out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          o_bus_sel = w_op == 4'h4 ? BUS_A : (w_op == 4'h1 || w_alu2) ? BUS_RAM : 3'd0;
          o_a_load = w_op == 4'h1;
          o_ram_wr = w_op == 4'h4;
          o_b_load = w_alu2;
        end
        T4: begin
          o_bus_sel = w_alu2 ? BUS_ALU : 3'd0;
          o_alu_op = w_alu2 ? w_alu_fn : 4'd0;
          o_a_load = w_alu2;
          o_flags_load = w_alu2;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/control_unit.md
# control_unit

Microcoded fetch/decode/execute sequencer for the 16-bit SAP computer. It steps a T-state counter, decodes the 4-bit opcode held in the instruction register, and drives every datapath control line: bus source select, register loads, RAM read/write, PC control, and the 4-bit `alu_op` consumed by the `alu` block. It is the initiator for the ALU: it presents operands via A/B loads, selects the operation, and latches the 17-bit result and flags.

## Interface

Parameters

- None. All widths are fixed by the SAP architecture.

Ports

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `step_en`  in  1  clock enable. When 0, state holds and all control outputs are 0.
- `instr`  in  16  IR contents. Opcode is `[15:12]`; operand/address is `[11:0]`. Valid from T2.
- `flag_c`  in  1  carry flag from the flags register.
- `flag_z`  in  1  zero flag from the flags register.
- `bus_sel`  out  3  bus source select: 0 none, 1 PC, 2 RAM, 3 IR operand (zero-extended), 4 A, 5 ALU result[15:0].
- `mar_load`  out  1  load MAR from the bus.
- `ram_wr`  out  1  write the bus to RAM[MAR].
- `ir_load`  out  1  load IR from the bus.
- `pc_inc`  out  1  PC += 1.
- `pc_load`  out  1  load PC from the bus.
- `a_load`  out  1  load register A from the bus.
- `b_load`  out  1  load register B from the bus.
- `flags_load`  out  1  capture C = alu res[16] and Z = (res[15:0] == 0).
- `out_load`  out  1  load the output register from the bus.
- `alu_op`  out  4  ALU operation: ADD 0, SUB 1, INC 2, DEC 3, AND 4, OR 5, XOR 6. It is 0 when not in use.
- `tstate`  out  3  current T-state (0–5).
- `halted`  out  1  high after HLT executes.

## Operation

- State consists of the T-state counter and the halt bit. Control outputs are decoded combinationally from the state, `instr`, and the flags.
- T0: `bus_sel`=PC, `mar_load`.
- T1: `bus_sel`=RAM, `ir_load`, `pc_inc`.
- Opcode execution steps (T2 onward):
  - 0 NOP: T2 empty, end.
  - 1 LDA: T2 IR→MAR. T3 RAM→A, end.
  - 2 ADD / 3 SUB / 9 AND / A OR / B XOR: T2 IR→MAR. T3 RAM→B. T4 `bus_sel`=ALU with matching `alu_op`, `a_load`, `flags_load`, end.
  - 4 STA: T2 IR→MAR. T3 `bus_sel`=A, `ram_wr`, end.
  - 5 LDI: T2 IR→A, end.
  - 6 JMP: T2 IR→PC (`pc_load`), end.
  - 7 JC / 8 JZ: T2 `bus_sel`=IR. `pc_load` is asserted only if `flag_c` (JC) or `flag_z` (JZ) is 1. The instruction ends at T2 either way.
  - C INC / D DEC: T2 `bus_sel`=ALU, `alu_op` 2 or 3, `a_load`, `flags_load`, end.
  - E OUT: T2 `bus_sel`=A, `out_load`, end.
  - F HLT: T2 sets `halted`. All controls are 0 from then until reset.
- "End" means the next state is T0. All 16 opcodes are defined; there is no illegal-opcode path.
- At most one bus source is active per cycle. `ram_wr` and `bus_sel`=RAM are never asserted together.

## Timing

- Reset values: `tstate`=0, `halted`=0. While `rst`=1, every control output is 0.
- The first fetch T0 occurs on the first cycle with `rst`=0 and `step_en`=1.
- Instruction lengths:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, INC, DEC, OUT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB, AND, OR, XOR.
- `step_en`=0 freezes `tstate` and forces controls to 0. Resuming continues at the same T-state.
- `rst` has priority over `step_en`. Reset mid-instruction aborts it and returns to T0 next cycle. Partially executed loads are not undone.
- Halted state ignores `step_en` and exits only via `rst`.
- Jump conditions are sampled in the T2 cycle only.
- `tstate` never exceeds 4 in normal operation. A value of 5 forces T0 on the next cycle.

## Test plan

- Reset release with `step_en`=1: T0 shows `bus_sel`=1 and `mar_load`=1. T1 shows `bus_sel`=2, `ir_load`=1, `pc_inc`=1. Nothing else is asserted.
- `instr`=16'h5123 (LDI 0x123): T2 gives `bus_sel`=3 and `a_load`=1. The next cycle is T0, for 3 cycles total.
- `instr`=16'h2040 (ADD [0x40]): T2 `mar_load`. T3 `bus_sel`=2 with `b_load`. T4 `bus_sel`=5, `alu_op`=0, `a_load`, `flags_load`. Then T0, for 5 cycles. Repeat with 3xxx, 9xxx, Axxx, Bxxx and expect `alu_op` 1, 4, 5, 6.
- JZ 8055: with `flag_z`=1, `pc_load`=1 at T2. With `flag_z`=0, `pc_load`=0. Both return to T0 after 3 cycles. Repeat for JC with `flag_c`.
- HLT F000: `halted`=1 from the cycle after T2, with all controls at 0 for 20+ cycles while toggling `step_en`. Then `rst`=1 for one cycle, after which `halted`=0 and `tstate`=0.
- STA 4010 with `step_en` dropped at T3 for 3 cycles: `tstate` holds at 3 and `ram_wr`=0 while stalled. `ram_wr`=1 with `bus_sel`=4 on resume. Separately, asserting `rst` at T3 of an ADD gives T0 next cycle with no `flags_load`.
